muxn_stage: RTL

//   Parametrised N-way operand select followed by a registered, back-pressured pipeline stage.

---
 rtl/muxn_pkg.sv | 17 +
 rtl/muxn_stage_if.sv | 27 ++
 rtl/muxn_skid.sv | 34 +++
 rtl/muxn_stage.sv | 139 +++++++++++++
 4 files changed

// File: rtl/muxn_pkg.sv
// Shared types and helpers for the muxn_stage select-and-register pipeline stage.
package muxn_pkg;

    localparam int unsigned MUXN_MAX_IN = 16;
    localparam int unsigned MUXN_MIN_IN = 2;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } stage_st_e;

    function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_in);
        return sel < num_in;
    endfunction

endpackage

// File: rtl/muxn_stage_if.sv
// Upstream beat, downstream beat and flush signals of one muxn_stage instance.
interface muxn_stage_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4
);
    localparam int unsigned SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;

    modport slave (
        input  in_data, sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_valid, sel_err
    );

    modport master (
        output in_data, sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_valid, sel_err
    );
endinterface

// File: rtl/muxn_skid.sv
// Second pipeline entry: holds the beat that arrives while the output register is stalled.
module muxn_skid #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             unload,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

    // Data needs no reset; valid qualifies it.
    always_ff @(posedge clk) begin
        if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/muxn_stage.sv
// N-way operand select into a registered valid/ready stage with a 2-entry skid and flush.
// Define MUXN_STAGE_SEL_CHECK_EN to build the sticky out-of-range select flag.
module muxn_stage
    import muxn_pkg::*;
#(
    parameter int unsigned     WIDTH     = 32,
    parameter int unsigned     NUM_IN    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic         clk,
    input logic         rst_n,
    muxn_stage_if.slave bus
);

    localparam int unsigned SEL_W = $clog2(NUM_IN);

    if (NUM_IN < MUXN_MIN_IN || NUM_IN > MUXN_MAX_IN) begin : g_bad_num_in
        $error("muxn_stage: NUM_IN=%0d outside supported range", NUM_IN);
    end

    stage_st_e        state_q, state_d;
    logic [WIDTH-1:0] out_data_q, mux_data, skid_q;
    logic             out_valid_q, in_ready_q, skid_valid;
    logic             out_valid_d, in_ready_d;
    logic             in_xfer, out_xfer, sel_ok;
    logic             load_mux, load_skid_out, skid_load, skid_unload;

    assign in_xfer  = bus.in_valid && in_ready_q;
    assign out_xfer = out_valid_q && bus.out_ready;
    assign sel_ok   = sel_in_range(32'(bus.sel), NUM_IN);

    // Out-of-range selects fall back to input 0.
    always_comb begin
        mux_data = bus.in_data[WIDTH-1:0];
        if (sel_ok) begin
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                if (bus.sel == SEL_W'(k)) begin
                    mux_data = bus.in_data[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (in_xfer) state_d = ONE;
                ONE: begin
                    if (in_xfer && !out_xfer)      state_d = TWO;
                    else if (!in_xfer && out_xfer) state_d = EMPTY;
                end
                TWO:     if (out_xfer) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        load_mux      = 1'b0;
        load_skid_out = 1'b0;
        skid_load     = 1'b0;
        skid_unload   = 1'b0;
        out_valid_d   = (state_d != EMPTY);
        in_ready_d    = (state_d != TWO);
        if (!bus.flush) begin
            case (state_q)
                EMPTY: load_mux = in_xfer;
                ONE: begin
                    load_mux  = in_xfer && out_xfer;
                    skid_load = in_xfer && !out_xfer;
                end
                TWO: begin
                    load_skid_out = out_xfer && skid_valid;
                    skid_unload   = out_xfer;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= RESET_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            if (bus.flush)          out_data_q <= RESET_VAL;
            else if (load_mux)      out_data_q <= mux_data;
            else if (load_skid_out) out_data_q <= skid_q;
        end
    end

    muxn_skid #(.WIDTH(WIDTH)) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (skid_load),
        .unload (skid_unload),
        .clear  (bus.flush),
        .d      (mux_data),
        .q      (skid_q),
        .valid  (skid_valid)
    );

`ifdef MUXN_STAGE_SEL_CHECK_EN
    logic sel_err_q;

    // Sticky until reset; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
        end else if (in_xfer && !sel_ok) begin
            sel_err_q <= 1'b1;
            $error("muxn_stage: sel=%0d out of range for NUM_IN=%0d", bus.sel, NUM_IN);
        end
    end

    assign bus.sel_err = sel_err_q;
`else
    assign bus.sel_err = 1'b0;
`endif

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;

endmodule
